mem_port_arbiter: RTL

//  N-port arbiter that shares one cache-line memory bus among NUM_PORTS cache clients.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_picker.sv | 32 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the cache-line memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arbiter FSM state encoding, default line width, round-robin wrap helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;

  localparam int MEM_LINE_WIDTH = 256;

  // Next round-robin position after v, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_PORTS.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (per-port request), ptr (search start), valid (any request), idx (winner).
module mem_port_arbiter_rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory bus among NUM_PORTS clients, round-robin, one transaction at a time.
// Latency: request in IDLE -> grant+strobe next cycle; mem response at k -> done at k+1; >=3 cycles/txn.
// Backpressure: clients hold level requests until done; a watchdog aborts a stalled memory with error.
// Ports: i_clock/i_reset; per-port address/read/write/wdata in, grant/done/error pulses and rdata out;
//        memory side address/read/write/wdata out, ready/rdata/done in.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = MEM_LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_port_address,
  input  logic [NUM_PORTS-1:0]            i_port_read,
  input  logic [NUM_PORTS-1:0]            i_port_write,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] i_port_wdata,
  output logic [NUM_PORTS-1:0]            o_port_grant,
  output logic [NUM_PORTS-1:0]            o_port_done,
  output logic [NUM_PORTS-1:0]            o_port_error,
  output logic [LINE_WIDTH-1:0]           o_port_rdata,
  output logic [ADDR_WIDTH-1:0]           o_mem_address,
  output logic                            o_mem_read,
  output logic                            o_mem_write,
  output logic [LINE_WIDTH-1:0]           o_mem_wdata,
  input  logic                            i_mem_ready,
  input  logic [LINE_WIDTH-1:0]           i_mem_rdata,
  input  logic                            i_mem_done
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // A disabled watchdog still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx;
  logic             is_write;
  logic [CNT_W-1:0] wd_cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             resp_hit;
  logic             wd_expired;

  mem_port_arbiter_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req   (i_port_read | i_port_write),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the response matching the latched op counts; the other type is ignored.
  assign resp_hit   = is_write ? i_mem_done : i_mem_ready;
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      idx           <= '0;
      is_write      <= 1'b0;
      wd_cnt        <= '0;
      o_port_grant  <= '0;
      o_port_done   <= '0;
      o_port_error  <= '0;
      o_port_rdata  <= '0;
      o_mem_address <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_wdata   <= '0;
    end else begin
      // Grant/done/error are single-cycle pulses.
      o_port_grant <= '0;
      o_port_done  <= '0;
      o_port_error <= '0;
      case (state)
        ARB_IDLE: begin
          o_port_rdata <= '0;
          if (pick_valid) begin
            idx           <= pick_idx;
            is_write      <= i_port_write[pick_idx];
            o_mem_address <= i_port_address[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            o_mem_wdata   <= i_port_wdata[int'(pick_idx)*LINE_WIDTH +: LINE_WIDTH];
            // Write wins when a port raises both read and write.
            o_mem_read    <= ~i_port_write[pick_idx];
            o_mem_write   <= i_port_write[pick_idx];
            o_port_grant  <= NUM_PORTS'(1) << pick_idx;
            wd_cnt        <= '0;
            state         <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A response in the watchdog's final cycle takes priority over the abort.
          if (resp_hit || wd_expired) begin
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_port_done  <= NUM_PORTS'(1) << idx;
            o_port_error <= resp_hit ? '0 : (NUM_PORTS'(1) << idx);
            o_port_rdata <= (resp_hit && !is_write) ? i_mem_rdata : '0;
            state        <= ARB_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ARB_RESP: begin
          rr_ptr <= IDX_W'(rr_next(int'(idx), NUM_PORTS));
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
